// File: rtl/regfile_pkg.sv
// Shared FunSel codes and next-value / wrap-flag helpers for the register file.
package regfile_pkg;

   // Widest register the helpers support; narrower registers are masked down.
   localparam int unsigned MAX_W = 64;

   localparam logic [2:0] FS_DEC  = 3'b000;
   localparam logic [2:0] FS_INC  = 3'b001;
   localparam logic [2:0] FS_LOAD = 3'b010;
   localparam logic [2:0] FS_CLR  = 3'b011;
   localparam logic [2:0] FS_LDB  = 3'b100;
   localparam logic [2:0] FS_LDH  = 3'b101;
   localparam logic [2:0] FS_SHB  = 3'b110;
   localparam logic [2:0] FS_LDHS = 3'b111;

   // All-ones mask covering the low w bits.
   function automatic logic [MAX_W-1:0] width_mask(input int unsigned w);
      logic [MAX_W-1:0] m;
      if (w >= MAX_W) m = {MAX_W{1'b1}};
      else            m = (MAX_W'(1) << w) - MAX_W'(1);
      return m;
   endfunction

   // Result of applying function fs to a w-bit register holding cur.
   function automatic logic [MAX_W-1:0] next_value(input logic [MAX_W-1:0] cur,
                                                   input logic [MAX_W-1:0] din,
                                                   input logic [2:0]       fs,
                                                   input int unsigned      w);
      logic [MAX_W-1:0] r;
      case (fs)
         FS_DEC:  r = cur - MAX_W'(1);
         FS_INC:  r = cur + MAX_W'(1);
         FS_LOAD: r = din;
         FS_CLR:  r = '0;
         FS_LDB:  r = {{(MAX_W-8){1'b0}}, din[7:0]};
         FS_LDH:  r = {{(MAX_W-16){1'b0}}, din[15:0]};
         FS_SHB:  r = {cur[MAX_W-9:0], din[7:0]};
         default: r = {{(MAX_W-16){din[15]}}, din[15:0]};
      endcase
      return r & width_mask(w);
   endfunction

   // INC of all-ones or DEC of zero wraps around.
   function automatic logic wrap_detect(input logic [MAX_W-1:0] cur,
                                        input logic [2:0]       fs,
                                        input int unsigned      w);
      return ((fs == FS_INC) && (cur == width_mask(w))) ||
             ((fs == FS_DEC) && (cur == '0));
   endfunction

   // Every function other than INC/DEC clears the sticky flag.
   function automatic logic wrap_clears(input logic [2:0] fs);
      return (fs != FS_INC) && (fs != FS_DEC);
   endfunction

endpackage

// File: rtl/reg_cell.sv
// One register plus its sticky wrap flag; swap overrides any write.
module reg_cell
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  en,
   input  logic [2:0]            funsel,
   input  logic [DATA_WIDTH-1:0] I,
   input  logic [DATA_WIDTH-1:0] swap_in,
   input  logic                  swap_flag_in,
   input  logic                  swap,
   output logic [DATA_WIDTH-1:0] value,
   output logic                  flag,
   output logic [DATA_WIDTH-1:0] next_value_c
);

   logic next_flag_c;

   // Next value and flag: swap first, then enabled write, else hold.
   always_comb begin
      next_value_c = value;
      next_flag_c  = flag;
      if (swap) begin
         next_value_c = swap_in;
         next_flag_c  = swap_flag_in;
      end else if (en) begin
         next_value_c = DATA_WIDTH'(next_value(MAX_W'(value), MAX_W'(I), funsel, DATA_WIDTH));
         if (wrap_detect(MAX_W'(value), funsel, DATA_WIDTH))
            next_flag_c = 1'b1;
         else if (wrap_clears(funsel))
            next_flag_c = 1'b0;
      end
   end

   // Register and flag state.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         value <= '0;
         flag  <= 1'b0;
      end else begin
         value <= next_value_c;
         flag  <= next_flag_c;
      end
   end

endmodule

// File: rtl/param_register_file.sv
// Parametrised GPR/scratch register file with two registered read ports,
// optional write-to-read bypass, sticky wrap flags and bank swap.
module param_register_file
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_GPR    = 4,
   parameter int unsigned NUM_SCR    = 4,
   parameter int unsigned BYPASS     = 1,
   parameter int unsigned SELW       = $clog2(NUM_GPR + NUM_SCR)
) (
   input  logic                          Clock,
   input  logic                          Reset,
   input  logic [DATA_WIDTH-1:0]         I,
   input  logic [2:0]                    FunSel,
   input  logic [NUM_GPR-1:0]            RegSel,
   input  logic [NUM_SCR-1:0]            ScrSel,
   input  logic                          Swap,
   input  logic [SELW-1:0]               OutASel,
   input  logic [SELW-1:0]               OutBSel,
   output logic [DATA_WIDTH-1:0]         OutA,
   output logic [DATA_WIDTH-1:0]         OutB,
   output logic [NUM_GPR+NUM_SCR-1:0]    WrapFlag
);

   localparam int unsigned NREG = NUM_GPR + NUM_SCR;

   logic [DATA_WIDTH-1:0] cur  [NREG];
   logic [DATA_WIDTH-1:0] nxt  [NREG];
   logic [DATA_WIDTH-1:0] src  [NREG];
   logic [DATA_WIDTH-1:0] sw_v [NREG];
   logic                  sw_f [NREG];
   logic                  en_w [NREG];
   logic                  flg  [NREG];
   logic [DATA_WIDTH-1:0] a_c, b_c;

   // Index order: R1..Rn then S1..Sm; enables are MSB-first within each bank.
   for (genvar i = 0; i < int'(NREG); i++) begin : g_cell
      if (i < int'(NUM_GPR)) begin : g_gpr
         assign en_w[i] = RegSel[NUM_GPR-1-i];
         if (i < int'(NUM_SCR)) begin : g_pair
            assign sw_v[i] = cur[i+NUM_GPR];
            assign sw_f[i] = flg[i+NUM_GPR];
         end else begin : g_solo
            assign sw_v[i] = cur[i];
            assign sw_f[i] = flg[i];
         end
      end else begin : g_scr
         assign en_w[i] = ScrSel[NREG-1-i];
         if ((i - int'(NUM_GPR)) < int'(NUM_GPR)) begin : g_pair
            assign sw_v[i] = cur[i-NUM_GPR];
            assign sw_f[i] = flg[i-NUM_GPR];
         end else begin : g_solo
            assign sw_v[i] = cur[i];
            assign sw_f[i] = flg[i];
         end
      end

      reg_cell #(.DATA_WIDTH(DATA_WIDTH)) u_cell (
         .Clock        (Clock),
         .Reset        (Reset),
         .en           (en_w[i]),
         .funsel       (FunSel),
         .I            (I),
         .swap_in      (sw_v[i]),
         .swap_flag_in (sw_f[i]),
         .swap         (Swap),
         .value        (cur[i]),
         .flag         (flg[i]),
         .next_value_c (nxt[i])
      );

      assign WrapFlag[i] = flg[i];
      assign src[i]      = (BYPASS != 0) ? nxt[i] : cur[i];
   end

   // Read muxes; selects beyond the last register return 0.
   always_comb begin
      a_c = '0;
      b_c = '0;
      for (int i = 0; i < int'(NREG); i++) begin
         if (OutASel == SELW'(i)) a_c = src[i];
         if (OutBSel == SELW'(i)) b_c = src[i];
      end
   end

   // Registered read ports.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         OutA <= '0;
         OutB <= '0;
      end else begin
         OutA <= a_c;
         OutB <= b_c;
      end
   end

endmodule

// File: tb/tb_param_register_file.sv
// Scoreboard bench for param_register_file: three configurations share one clock.
module tb_param_register_file;

   localparam logic [2:0] DEC  = 3'b000;
   localparam logic [2:0] INC  = 3'b001;
   localparam logic [2:0] LOAD = 3'b010;
   localparam logic [2:0] CLR  = 3'b011;
   localparam logic [2:0] LDB  = 3'b100;
   localparam logic [2:0] SHB  = 3'b110;
   localparam logic [2:0] LDHS = 3'b111;

   localparam int W_AA = 0, W_AB = 1, W_AW = 2, W_BA = 3, W_CA = 4, W_CW = 5;

   logic clk, rst;

   // a: 32-bit 4+4 bypass, b: 32-bit 4+4 no bypass, c: 16-bit 2+3 bypass
   logic [31:0] a_i, a_outa, a_outb;  logic [2:0] a_fs;  logic [3:0] a_rs, a_ss;
   logic a_swap;  logic [2:0] a_asel, a_bsel;  logic [7:0] a_wrap;
   logic [31:0] b_i, b_outa, b_outb;  logic [2:0] b_fs;  logic [3:0] b_rs, b_ss;
   logic b_swap;  logic [2:0] b_asel, b_bsel;  logic [7:0] b_wrap;
   logic [15:0] c_i, c_outa, c_outb;  logic [2:0] c_fs;  logic [1:0] c_rs;
   logic [2:0] c_ss;  logic c_swap;  logic [2:0] c_asel, c_bsel;  logic [4:0] c_wrap;

   param_register_file #(.DATA_WIDTH(32), .NUM_GPR(4), .NUM_SCR(4), .BYPASS(1)) u_a (
      .Clock(clk), .Reset(rst), .I(a_i), .FunSel(a_fs), .RegSel(a_rs), .ScrSel(a_ss),
      .Swap(a_swap), .OutASel(a_asel), .OutBSel(a_bsel), .OutA(a_outa), .OutB(a_outb),
      .WrapFlag(a_wrap));

   param_register_file #(.DATA_WIDTH(32), .NUM_GPR(4), .NUM_SCR(4), .BYPASS(0)) u_b (
      .Clock(clk), .Reset(rst), .I(b_i), .FunSel(b_fs), .RegSel(b_rs), .ScrSel(b_ss),
      .Swap(b_swap), .OutASel(b_asel), .OutBSel(b_bsel), .OutA(b_outa), .OutB(b_outb),
      .WrapFlag(b_wrap));

   param_register_file #(.DATA_WIDTH(16), .NUM_GPR(2), .NUM_SCR(3), .BYPASS(1)) u_c (
      .Clock(clk), .Reset(rst), .I(c_i), .FunSel(c_fs), .RegSel(c_rs), .ScrSel(c_ss),
      .Swap(c_swap), .OutASel(c_asel), .OutBSel(c_bsel), .OutA(c_outa), .OutB(c_outb),
      .WrapFlag(c_wrap));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      int          due;
      int          which;
      logic [63:0] val;
   } exp_t;

   exp_t sb[$];
   int   cyc     = 0;
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [63:0] observe(input int which);
      case (which)
         W_AA:    return 64'(a_outa);
         W_AB:    return 64'(a_outb);
         W_AW:    return 64'(a_wrap);
         W_BA:    return 64'(b_outa);
         W_CA:    return 64'(c_outa);
         default: return 64'(c_wrap);
      endcase
   endfunction

   task automatic expect_at(input string tag, input int lat, input int which,
                            input logic [63:0] val);
      exp_t e;
      e.tag = tag;  e.due = cyc + lat;  e.which = which;  e.val = val;
      sb.push_back(e);
   endtask

   // Advance one edge, then compare every scoreboard entry due now.
   task automatic cycle();
      @(posedge clk);
      #1;
      cyc++;
      for (int k = sb.size() - 1; k >= 0; k--) begin
         if (sb[k].due <= cyc) begin
            check_val(sb[k].tag, observe(sb[k].which), sb[k].val);
            sb.delete(k);
         end
      end
   endtask

   task automatic idle();
      a_i = '0; a_fs = '0; a_rs = '0; a_ss = '0; a_swap = 1'b0;
      b_i = '0; b_fs = '0; b_rs = '0; b_ss = '0; b_swap = 1'b0;
      c_i = '0; c_fs = '0; c_rs = '0; c_ss = '0; c_swap = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      a_asel = '0; a_bsel = '0; b_asel = '0; b_bsel = '0; c_asel = '0; c_bsel = '0;
      cycle();
      cycle();
      check_val("rst_a_outa", 64'(a_outa), 64'h0);
      check_val("rst_a_wrap", 64'(a_wrap), 64'h0);
      rst = 1'b0;

      // c1
      idle();
      a_fs = LOAD; a_rs = 4'b1000; a_i = 32'hAB; a_asel = 3'd0;
      expect_at("a_load_r1", 1, W_AA, 64'hAB);
      c_fs = LOAD; c_ss = 3'b001; c_i = 16'h1234; c_asel = 3'd5;
      expect_at("c_sel5_first", 1, W_CA, 64'h0);
      cycle();
      // c2
      idle();
      a_fs = SHB; a_rs = 4'b1000; a_i = 32'hCD;
      expect_at("a_shb", 1, W_AA, 64'h0000ABCD);
      c_fs = SHB; c_ss = 3'b001; c_i = 16'h56; c_asel = 3'd4;
      expect_at("c_shb16", 1, W_CA, 64'h3456);
      cycle();
      // c3
      idle();
      a_fs = LDHS; a_rs = 4'b1000; a_i = 32'h8001;
      expect_at("a_ldhs", 1, W_AA, 64'hFFFF8001);
      c_swap = 1'b1; c_rs = 2'b11; c_fs = CLR; c_asel = 3'd4;
      expect_at("c_s3_no_swap", 1, W_CA, 64'h3456);
      cycle();
      // c4
      idle();
      a_fs = LDB; a_rs = 4'b1000; a_i = 32'h1FF;
      expect_at("a_ldb", 1, W_AA, 64'hFF);
      c_asel = 3'd5;
      expect_at("c_sel5_oob", 1, W_CA, 64'h0);
      cycle();
      // c5
      idle();
      a_fs = DEC; a_ss = 4'b0100; a_asel = 3'd5;
      expect_at("a_dec_s2", 1, W_AA, 64'hFFFFFFFF);
      expect_at("a_wrap_set", 1, W_AW, 64'h20);
      c_fs = DEC; c_rs = 2'b10; c_asel = 3'd0;
      expect_at("c_dec_r1", 1, W_CA, 64'hFFFF);
      expect_at("c_wrap_r1", 1, W_CW, 64'h01);
      cycle();
      // c6
      idle();
      a_fs = INC; a_ss = 4'b0100;
      expect_at("a_inc_s2", 1, W_AA, 64'h0);
      expect_at("a_wrap_sticky", 1, W_AW, 64'h20);
      cycle();
      // c7
      idle();
      a_fs = LOAD; a_ss = 4'b0100; a_i = 32'h5;
      expect_at("a_load_s2", 1, W_AA, 64'h5);
      expect_at("a_wrap_clear", 1, W_AW, 64'h0);
      b_fs = LOAD; b_rs = 4'b0010; b_i = 32'h11;
      cycle();
      // c8
      idle();
      a_fs = LOAD; a_rs = 4'b0010; a_i = 32'h55; a_asel = 3'd2;
      expect_at("a_bypass", 1, W_AA, 64'h55);
      b_fs = LOAD; b_rs = 4'b0010; b_i = 32'h55; b_asel = 3'd2;
      expect_at("b_nobypass_old", 1, W_BA, 64'h11);
      expect_at("b_nobypass_new", 2, W_BA, 64'h55);
      cycle();
      // c9..c13: S1=9, then R1 wraps down and counts back up to 1
      idle(); a_fs = LOAD; a_ss = 4'b1000; a_i = 32'h9;  cycle();
      idle(); a_fs = CLR;  a_rs = 4'b1000;               cycle();
      idle(); a_fs = DEC;  a_rs = 4'b1000;               cycle();
      idle(); a_fs = INC;  a_rs = 4'b1000;               cycle();
      idle(); a_fs = INC;  a_rs = 4'b1000; a_asel = 3'd0;
      expect_at("a_r1_one", 1, W_AA, 64'h1);
      expect_at("a_r1_flag", 1, W_AW, 64'h01);
      cycle();
      // c14: swap wins over CLR
      idle();
      a_swap = 1'b1; a_rs = 4'b1111; a_fs = CLR; a_asel = 3'd0; a_bsel = 3'd4;
      expect_at("a_swap_r1", 1, W_AA, 64'h9);
      expect_at("a_swap_s1", 1, W_AB, 64'h1);
      expect_at("a_swap_flag", 1, W_AW, 64'h10);
      cycle();
      // c15
      idle();
      a_fs = DEC; a_ss = 4'b0001; a_asel = 3'd6; a_bsel = 3'd1;
      expect_at("a_r3_to_s3", 1, W_AA, 64'h55);
      expect_at("a_s2_to_r2", 1, W_AB, 64'h5);
      expect_at("a_wrap_s1_s4", 1, W_AW, 64'h90);
      cycle();
      // c16
      idle();
      a_fs = LOAD; a_rs = 4'b1111; a_ss = 4'b1110; a_i = 32'hDEADBEEF;
      a_asel = 3'd0; a_bsel = 3'd7;
      expect_at("a_load_all", 1, W_AA, 64'hDEADBEEF);
      expect_at("a_s4_held", 1, W_AB, 64'hFFFFFFFF);
      expect_at("a_wrap_s4", 1, W_AW, 64'h80);
      cycle();
      // asynchronous reset mid-cycle
      idle();
      rst = 1'b1;
      #1;
      check_val("arst_outa", 64'(a_outa), 64'h0);
      check_val("arst_outb", 64'(a_outb), 64'h0);
      check_val("arst_wrap", 64'(a_wrap), 64'h0);
      rst = 1'b0;
      a_asel = 3'd3;
      expect_at("a_r4_cleared", 1, W_AA, 64'h0);
      cycle();
      cycle();

      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain: got %0d pending entries expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/param_register_file.md
# param_register_file

Parametrised successor to the datapath's 8-entry register file: NUM_GPR general-purpose registers (R1..Rn) and NUM_SCR scratch registers (S1..Sm) of DATA_WIDTH bits, two registered read ports, and the same 8-function write unit. It adds the following, and sits between the ALU result bus and the ALU operand muxes:

- asynchronous reset;
- optional same-cycle write-to-read bypass;
- sticky per-register wrap flags for increment/decrement;
- a single-cycle GPR/scratch bank swap for fast context save.

## Interface
Parameters:
- DATA_WIDTH, 32, register width; legal range ≥16.
- NUM_GPR, 4, number of general-purpose registers; legal range 1..8.
- NUM_SCR, 4, number of scratch registers; legal range 1..8.
- BYPASS, 1, read-port forwarding: 1 = read ports return the value being written, 0 = read ports return the pre-write value.
- SELW, derived, $clog2(NUM_GPR+NUM_SCR), read-select width.

Ports:
- Clock, in, 1, single clock; all state updates on rising edge.
- Reset, in, 1, asynchronous, active-high; clears all state.
- I, in, DATA_WIDTH, write data.
- FunSel, in, 3, write function, applied to every enabled register.
- RegSel, in, NUM_GPR, GPR write enables; bit NUM_GPR-1 = R1, bit 0 = Rn.
- ScrSel, in, NUM_SCR, scratch write enables; bit NUM_SCR-1 = S1, bit 0 = Sm.
- Swap, in, 1, bank-swap command.
- OutASel, in, SELW, port-A select: 0..NUM_GPR-1 = R1..Rn, NUM_GPR.. = S1..Sm.
- OutBSel, in, SELW, port-B select, same encoding as OutASel.
- OutA, out, DATA_WIDTH, registered read port A.
- OutB, out, DATA_WIDTH, registered read port B.
- WrapFlag, out, NUM_GPR+NUM_SCR, sticky wrap flag per register, same index order as the read select.

## Operation
FunSel functions, applied to each register whose enable bit is 1:
- 000 DEC: reg − 1, modulo 2^DATA_WIDTH.
- 001 INC: reg + 1, modulo 2^DATA_WIDTH.
- 010 LOAD: I.
- 011 CLR: 0.
- 100 LDB: zero-extended I[7:0].
- 101 LDH: zero-extended I[15:0].
- 110 SHB: {reg[DATA_WIDTH−9:0], I[7:0]}.
- 111 LDHS: sign-extended I[15:0].

Wrap flags:
- Set when INC is applied to an all-ones register or DEC to a zero register.
- Cleared by LOAD, CLR, LDB, LDH, SHB or LDHS to that register.
- Otherwise held.

Swap:
- When Swap=1, every Rk exchanges value and wrap flag with Sk, for k ≤ min(NUM_GPR, NUM_SCR).
- FunSel/RegSel/ScrSel are ignored in that cycle; Swap has priority.
- Registers without a partner hold their value.

Read ports:
- Each port registers the selected register every cycle; there is no read enable.
- A select value ≥ NUM_GPR+NUM_SCR reads 0.
- BYPASS=1: the port captures the register's next-state value (write or swap result in the same cycle).
- BYPASS=0: the port captures the current value.
- Both ports may select the same register.

## Timing
- Reset asserted: all registers, OutA, OutB and WrapFlag go to 0 immediately and hold while Reset=1.
- Reset deasserts synchronously to the first rising edge; an edge coincident with deassertion performs no write.
- Write latency: 1 edge; the value is visible in the register from the next cycle.
- Read latency: 1 edge from select to OutA/OutB.
  - A write and a read of the same register in the same cycle shows the new value after 1 edge (BYPASS=1) or 2 edges (BYPASS=0).
- Reset mid-sequence, e.g. an SHB chain, discards partial data; there is no resume.
- All-zero RegSel/ScrSel with Swap=0: no state change except the read ports.

## Structure
- Package regfile_pkg holds:
  - FunSel codes as localparams (FS_DEC..FS_LDHS);
  - a function for the DATA_WIDTH next-value computation;
  - the wrap-detect condition.
- Sub-module reg_cell holds one register plus its wrap flag, with inputs en, funsel, I, swap_in, swap_flag_in, swap.
  - It is instantiated NUM_GPR+NUM_SCR times via generate.
  - It exports the current value and next value; next value feeds the bypass.
- Top level holds the swap wiring and two read muxes with out-of-range → 0.

## Test plan
- Reset: assert Reset with all registers loaded 0xDEADBEEF → OutA, OutB and WrapFlag read 0 before the next Clock edge.
- Functions, DATA_WIDTH=32, starting from R1=0x000000AB:
  - SHB with I=0xCD → R1=0x0000ABCD;
  - then LDHS with I=0x8001 → 0xFFFF8001;
  - then LDB with I=0x1FF → 0x000000FF.
- Wrap: DEC on S2=0 → S2=0xFFFFFFFF, WrapFlag[NUM_GPR+1]=1; a further INC leaves the flag 1; LOAD with I=5 clears it.
- Bypass:
  - BYPASS=1, LOAD R3 with I=0x55 while OutASel=R3 → OutA=0x55 after 1 edge.
  - BYPASS=0, same stimulus → old value after 1 edge, 0x55 after 2 edges.
- Swap: R1=1, S1=9 with R1 wrap flag set; Swap=1 with RegSel=all-ones and FunSel=CLR → R1=9, S1=1, flag moves to S1, no register cleared.
- Parametrisation: NUM_GPR=2, NUM_SCR=3, DATA_WIDTH=16:
  - OutASel=5 reads 0;
  - S3 does not move on Swap;
  - SHB on 0x1234 with I=0x56 gives 0x3456.
